// File: rtl/thumb_fetch_pkg.sv
// Shared constants, entry layout and Thumb-2 prefix decode for the fetch stage.
package thumb_fetch_pkg;

  localparam int unsigned HW_BYTES   = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned HW_W       = 16;

  localparam logic [4:0] T32_PFX_A = 5'b11101;
  localparam logic [4:0] T32_PFX_B = 5'b11110;
  localparam logic [4:0] T32_PFX_C = 5'b11111;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic is_t32(input logic [HW_W-1:0] hw);
    return hw[15:11] inside {T32_PFX_A, T32_PFX_B, T32_PFX_C};
  endfunction

endpackage

// File: rtl/thumb_fetch_unit_fifo.sv
// Prefetch FIFO: word plus its address per entry, flushable, async active-high reset.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/thumb_fetch_unit.sv
// Thumb fetch stage: word prefetch, halfword delivery, ld_pc pulse, branch flush.
// FETCH_T32_DETECT_EN adds instr_is32 and holds a 32-bit pair until both halves are buffered.
module thumb_fetch_unit
  import thumb_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        ld_pc
`ifdef FETCH_T32_DETECT_EN
  ,
  output logic        instr_is32
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             hw_sel_q, hw_sel_d;
  logic             ld_pc_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head, tail;
  logic [15:0]      head_hw;
  logic             req_acc, consume, hw_valid, credit;
  logic             unused_bt0;

  assign unused_bt0 = branch_target[0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (tail),
    .pop_i   (fifo_pop),
    .flush_i (branch),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
  assign credit    = !fifo_full && ((32'(fifo_count) + 32'(out_q)) < DEPTH);
  assign imem_req  = !rst && credit;
  assign imem_addr = fetch_addr_q;
  assign req_acc   = imem_req && imem_gnt;
  assign tail      = '{addr: resp_addr_q, data: imem_rdata};

  assign head_hw  = hw_sel_q ? head.data[31:16] : head.data[15:0];
  assign instr    = fifo_empty ? '0 : head_hw;
  assign instr_pc = fifo_empty ? '0 : head.addr + (hw_sel_q ? 32'(HW_BYTES) : 32'd0);

`ifdef FETCH_T32_DETECT_EN
  assign instr_is32 = is_t32(head_hw);
  assign hw_valid   = !fifo_empty &&
                      !(instr_is32 && hw_sel_q && (fifo_count == CNT_W'(1)));
`else
  assign hw_valid   = !fifo_empty;
`endif

  assign instr_valid = hw_valid;
  assign consume     = hw_valid && instr_ready;
  assign ld_pc       = ld_pc_q;

  always_comb begin
    fetch_addr_d = fetch_addr_q;
    resp_addr_d  = resp_addr_q;
    out_d        = out_q + CNT_W'(req_acc) - CNT_W'(imem_rvalid);
    drop_d       = drop_q;
    hw_sel_d     = hw_sel_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    if (req_acc) fetch_addr_d = fetch_addr_q + 32'(WORD_BYTES);
    if (branch) begin
      // Every read still in flight after this edge, including one granted now, is stale.
      fetch_addr_d = {branch_target[31:2], 2'b00};
      resp_addr_d  = {branch_target[31:2], 2'b00};
      drop_d       = out_d;
      hw_sel_d     = branch_target[1];
    end else begin
      if (imem_rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else begin
          fifo_push   = 1'b1;
          resp_addr_d = resp_addr_q + 32'(WORD_BYTES);
        end
      end
      if (consume) begin
        if (hw_sel_q) begin
          fifo_pop = 1'b1;
          hw_sel_d = 1'b0;
        end else begin
          hw_sel_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_q <= RESET_PC;
      resp_addr_q  <= RESET_PC;
      out_q        <= '0;
      drop_q       <= '0;
      hw_sel_q     <= 1'b0;
      ld_pc_q      <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      resp_addr_q  <= resp_addr_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
      hw_sel_q     <= hw_sel_d;
      ld_pc_q      <= fifo_pop;
    end
  end

endmodule
